alu_serial_seq: RTL and testbench

Bit-serial sequencer that drives a single 1-bit ALU slice (`alu1`) over `WIDTH` cycles to execute a full-width operation. It accepts an operand pair and opcode through a start/ready handshake, then shifts operands through the slice LSB-first, carrying the slice's carry between cycles. It assembles the result word and reports completion. It sits between the instruction/control logic and one `alu1` instance, trading latency for area versus a ripple `alu4`.

---
 rtl/alu_serial_seq_pkg.sv | 38 +++
 rtl/alu_serial_dp.sv | 60 ++++++
 rtl/alu_serial_seq.sv | 102 ++++++++++
 tb/tb_alu_serial_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_seq_pkg.sv
// Shared opcode, slice-select and FSM encodings for the bit-serial ALU sequencer.
// The helper maps an opcode to the mux8 select code of the external 1-bit slice.
package alu_serial_seq_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;

    localparam logic [2:0] SEL_AND = 3'd7;
    localparam logic [2:0] SEL_NOT = 3'd6;
    localparam logic [2:0] SEL_OR  = 3'd5;
    localparam logic [2:0] SEL_XOR = 3'd4;
    localparam logic [2:0] SEL_ADD = 3'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Illegal opcodes (6, 7) drive select 0 so the slice output is a don't-care.
    function automatic logic [2:0] op_to_sel(input logic [2:0] op);
        case (op)
            OP_AND:         op_to_sel = SEL_AND;
            OP_OR:          op_to_sel = SEL_OR;
            OP_XOR:         op_to_sel = SEL_XOR;
            OP_NOT:         op_to_sel = SEL_NOT;
            OP_ADD, OP_SUB: op_to_sel = SEL_ADD;
            default:        op_to_sel = 3'd0;
        endcase
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        op_is_arith = (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_dp.sv
// Datapath: operand shift registers, inter-bit carry register, bit counter and result shifter.
// One bit per shift cycle, LSB first; load takes priority over shift.
module alu_serial_dp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_init,
    input  logic             carry_en,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic             a_bit,
    output logic             b_bit,
    output logic             carry_bit,
    output logic             last,
    output logic [WIDTH-1:0] res_next
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry_q;

    assign a_bit     = a_sr[0];
    assign b_bit     = b_sr[0];
    assign carry_bit = carry_q;
    assign last      = (cnt == CW'(WIDTH - 1));
    // Result fills from the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next  = {slice_out, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            res_sr  <= '0;
            cnt     <= '0;
            carry_q <= carry_init;
        end else if (shift) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            res_sr  <= res_next;
            cnt     <= cnt + 1'b1;
            carry_q <= carry_en ? slice_cout : 1'b0;
        end
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer driving one external 1-bit slice over WIDTH cycles.
// Start-to-done latency WIDTH+1 cycles; start is ignored while ready is low (no queuing).
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             illegal,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_select,
    input  logic             slice_out,
    input  logic             slice_cout
);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic             accept;
    logic             run;
    logic             last;
    logic             a_bit;
    logic             b_bit;
    logic             carry_bit;
    logic             illegal_op;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    assign accept     = (state == ST_IDLE) && start;
    assign run        = (state == ST_RUN);
    assign illegal_op = op_q[2] && op_q[1];

    alu_serial_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .shift      (run),
        .a_in       (a_in),
        .b_in       (b_in),
        .carry_init (op == OP_SUB),
        .carry_en   (op_is_arith(op_q)),
        .slice_out  (slice_out),
        .slice_cout (slice_cout),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .carry_bit  (carry_bit),
        .last       (last),
        .res_next   (res_next)
    );

    // SUB is a + ~b + 1: invert the B bit here, the carry reg was preset on accept.
    assign slice_a      = run && a_bit;
    assign slice_b      = run && (b_bit ^ (op_q == OP_SUB));
    assign slice_cin    = run && carry_bit;
    assign slice_select = run ? op_to_sel(op_q) : 3'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            op_q  <= OP_AND;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state <= ST_RUN;
                    op_q  <= op;
                end
                ST_RUN:  if (last) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Visible result and carry update only on entry to DONE, holding across later ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else if (run && last) begin
            result_q <= illegal_op ? '0 : res_next;
            carry_q  <= op_is_arith(op_q) ? slice_cout : 1'b0;
        end
    end

    assign ready     = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign illegal   = done && illegal_op;
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq with a behavioural 1-bit slice; scoreboard queue checked by a done monitor.
module tb_alu_serial_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ready, done, carry_out, illegal;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_cin, slice_out, slice_cout;
    logic [2:0]   slice_select;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .ready        (ready),
        .done         (done),
        .result       (result),
        .carry_out    (carry_out),
        .illegal      (illegal),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_select (slice_select),
        .slice_out    (slice_out),
        .slice_cout   (slice_cout)
    );

    // Behavioural alu1: mux8 of AND/NOT/OR/XOR/ADD.
    always_comb begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_select)
            3'd7: slice_out = slice_a & slice_b;
            3'd6: slice_out = ~slice_a;
            3'd5: slice_out = slice_a | slice_b;
            3'd4: slice_out = slice_a ^ slice_b;
            3'd3: begin
                slice_out  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
            end
            default: ;
        endcase
    end

    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         ill;
        int           idx;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] held = '0;
    int           checks = 0;
    int           failures = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            held = '0;
        end else if (done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done result=%h carry=%b illegal=%b cycle=%0d",
                         result, carry_out, illegal, pcnt);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res || carry_out !== mon_e.cy ||
                    illegal !== mon_e.ill || pcnt != mon_e.idx) begin
                    failures++;
                    $display("FAIL done_check got res=%h cy=%b ill=%b cycle=%0d exp res=%h cy=%b ill=%b cycle=%0d",
                             result, carry_out, illegal, pcnt,
                             mon_e.res, mon_e.cy, mon_e.ill, mon_e.idx);
                end
            end
            held = result;
        end else begin
            checks++;
            if (result !== held) begin
                failures++;
                $display("FAIL result_hold got=%h exp=%h cycle=%0d", result, held, pcnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] er, input logic ec, input logic ei,
                         output int acc);
        for (int t = 0; t < 50 && !ready; t++) @(negedge clk);
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout op=%0d", o);
        end
        op = o;
        a_in = a;
        b_in = b;
        start = 1'b1;
        acc = pcnt;
        if (push) sb.push_back('{er, ec, ei, pcnt + W + 1});
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        a_in = '0;
        b_in = '0;
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int acc0, acc1;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'({done, result, carry_out, illegal, slice_a, slice_b, slice_cin, slice_select}), 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        issue(3'd4, 4'h9, 4'h8, 1'b1, 4'h1, 1'b1, 1'b0, acc0);
        drain();

        // Back-to-back stream; each accept should follow the previous by WIDTH+2 cycles.
        issue(3'd5, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0, acc0);
        chk("sub_slice_bits", 32'({slice_a, slice_b, slice_cin, slice_select}), 32'({1'b1, 1'b0, 1'b1, 3'd3}));
        issue(3'd5, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0, acc1);
        chk("b2b_gap_sub", 32'(acc1 - acc0), 32'(W + 2));
        acc0 = acc1;
        issue(3'd2, 4'hA, 4'h5, 1'b1, 4'hF, 1'b0, 1'b0, acc1);
        chk("b2b_gap_xor", 32'(acc1 - acc0), 32'(W + 2));
        issue(3'd0, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0, acc1);
        issue(3'd1, 4'hC, 4'hA, 1'b1, 4'hE, 1'b0, 1'b0, acc1);
        issue(3'd3, 4'h3, 4'h0, 1'b1, 4'hC, 1'b0, 1'b0, acc1);
        drain();

        // Start pulsed mid-RUN must be dropped.
        issue(3'd4, 4'h6, 4'h7, 1'b1, 4'hD, 1'b0, 1'b0, acc0);
        @(negedge clk);
        chk("busy_ready_low", 32'(ready), 32'd0);
        op = 3'd5;
        a_in = 4'hF;
        b_in = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(3'd2, 4'h3, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, acc1);
        chk("ignored_start_gap", 32'(acc1 - acc0), 32'(W + 2));
        drain();

        // Reset during bit 2 of an ADD.
        issue(3'd4, 4'h5, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0, acc0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({done, result, carry_out, illegal, slice_a, slice_b, slice_cin, slice_select}), 32'd0);
        chk("rst_mid_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(3'd4, 4'h7, 4'h9, 1'b1, 4'h0, 1'b1, 1'b0, acc0);
        drain();

        issue(3'd7, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, acc0);
        issue(3'd0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, acc1);
        chk("b2b_gap_illegal", 32'(acc1 - acc0), 32'(W + 2));
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", pcnt);
        $fatal(1, "timeout");
    end

endmodule
